ulpi_phy_sequencer: RTL

Drives the ulpi_controller CSR port (AXI-Lite master) to bring the ULPI PHY up after reset and reconfigure it at runtime.
- Power-up: reads the PHY vendor/product ID, soft-resets the PHY, then programs Function Control and OTG Control.
- Runtime: reapplies speed, termination, opmode and suspend settings on request.
- Reports PHY ready/error status to the USB device core.

---
 rtl/ulpi_phy_sequencer_if.sv | 35 +++
 rtl/ulpi_phy_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_phy_sequencer_if.sv
// AXI-Lite CSR channel bundle between the PHY sequencer
// and the ulpi_controller register port.
interface axi_lite_iface;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb,
    output bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb,
    input  bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/ulpi_phy_sequencer.sv
// ULPI PHY bring-up and runtime reconfiguration sequencer
// driving the ulpi_controller CSR port over AXI-Lite.
module ulpi_phy_sequencer #(
  parameter int         INIT_DELAY = 1024,
  parameter int         TIMEOUT    = 255,
  parameter int         POLL_MAX   = 16,
  parameter logic [7:0] OTG_CTRL   = 8'h00
) (
  input  logic        ulpi_clk,
  input  logic        ulpi_rst,
  axi_lite_iface.master csr,
  input  logic [1:0]  cfg_xcvr_select,
  input  logic        cfg_term_select,
  input  logic [1:0]  cfg_op_mode,
  input  logic        cfg_suspend,
  input  logic        cfg_update,
  output logic        phy_ready,
  output logic        phy_error,
  output logic        busy,
  output logic [15:0] vendor_id,
  output logic [15:0] product_id
);

  typedef enum logic [3:0] {
    S_WAIT, S_ID, S_PHY_RST, S_POLL, S_FUNC,
    S_OTG, S_READY, S_UPD, S_ERROR
  } st_e;

  typedef enum logic [2:0] {
    B_IDLE, B_AW, B_W, B_B, B_AR, B_R
  } bs_e;

  st_e         st_q, st_d;
  bs_e         bs_q, bs_d;
  logic [15:0] dly_q, dly_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        pend_q, pend_d;
  logic        rdy_q, rdy_d;
  logic        err_q, err_d;
  logic [15:0] vid_q, vid_d;
  logic [15:0] pid_q, pid_d;
  logic [5:0]  addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        awv_q, wv_q, arv_q, busy_q;

  logic        hs, done, tmo, idle;
  logic        launch, l_wr;
  logic [5:0]  l_addr;
  logic [7:0]  l_data, func_val, rbyte;
  logic        unused_ok;

  assign idle     = (bs_q == B_IDLE);
  assign rbyte    = csr.rdata[7:0];
  assign func_val = {1'b0, ~cfg_suspend, 1'b0, cfg_op_mode,
                     cfg_term_select, cfg_xcvr_select};

  always_comb begin
    hs = 1'b0;
    unique case (bs_q)
      B_AW:    hs = csr.awready;
      B_W:     hs = csr.wready;
      B_B:     hs = csr.bvalid;
      B_AR:    hs = csr.arready;
      B_R:     hs = csr.rvalid;
      default: hs = 1'b0;
    endcase
  end

  assign done = hs & ((bs_q == B_B) | (bs_q == B_R));
  assign tmo  = ~idle & ~hs & (cnt_q == 16'(TIMEOUT - 1));

  always_comb begin
    st_d   = st_q;
    dly_d  = dly_q;
    idx_d  = idx_q;
    pcnt_d = pcnt_q;
    pend_d = pend_q;
    rdy_d  = rdy_q;
    err_d  = err_q;
    vid_d  = vid_q;
    pid_d  = pid_q;
    launch = 1'b0;
    l_wr   = 1'b0;
    l_addr = 6'h04;
    l_data = func_val;
    if (cfg_update && st_q != S_ERROR) pend_d = 1'b1;
    unique case (st_q)
      S_WAIT: begin
        if (dly_q == 16'(INIT_DELAY - 1)) begin
          st_d  = S_ID;
          idx_d = 2'd0;
        end else begin
          dly_d = dly_q + 16'd1;
        end
      end
      S_ID: begin
        launch = idle;
        l_addr = {4'd0, idx_q};
        if (done) begin
          unique case (idx_q)
            2'd0: vid_d[7:0]  = rbyte;
            2'd1: vid_d[15:8] = rbyte;
            2'd2: pid_d[7:0]  = rbyte;
            2'd3: pid_d[15:8] = rbyte;
          endcase
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) st_d = S_PHY_RST;
        end
      end
      S_PHY_RST: begin
        launch = idle;
        l_wr   = 1'b1;
        l_data = func_val | 8'h20;
        if (done) begin
          st_d   = S_POLL;
          pcnt_d = 8'd0;
        end
      end
      S_POLL: begin
        launch = idle;
        if (done) begin
          if (!rbyte[5]) begin
            st_d = S_FUNC;
          end else if (pcnt_q == 8'(POLL_MAX - 1)) begin
            st_d  = S_ERROR;
            err_d = 1'b1;
          end else begin
            pcnt_d = pcnt_q + 8'd1;
          end
        end
      end
      S_FUNC: begin
        launch = idle;
        l_wr   = 1'b1;
        if (done) st_d = S_OTG;
      end
      S_OTG: begin
        launch = idle;
        l_wr   = 1'b1;
        l_addr = 6'h0A;
        l_data = OTG_CTRL;
        if (done) begin
          st_d  = S_READY;
          rdy_d = 1'b1;
        end
      end
      S_READY: begin
        // a pulse seen here is served by this S_UPD write
        if (cfg_update || pend_q) begin
          st_d   = S_UPD;
          pend_d = 1'b0;
        end
      end
      S_UPD: begin
        launch = idle;
        l_wr   = 1'b1;
        if (done) st_d = S_READY;
      end
      S_ERROR: begin
        pend_d = 1'b0;
        rdy_d  = 1'b0;
      end
      default: st_d = S_ERROR;
    endcase
    if (tmo) begin
      st_d  = S_ERROR;
      err_d = 1'b1;
      rdy_d = 1'b0;
    end
  end

  always_comb begin
    bs_d   = bs_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    if (idle) begin
      if (launch) begin
        bs_d   = l_wr ? B_AW : B_AR;
        addr_d = l_addr;
        data_d = l_data;
        cnt_d  = 16'd0;
      end
    end else if (hs) begin
      cnt_d = 16'd0;
      unique case (bs_q)
        B_AW:    bs_d = B_W;
        B_W:     bs_d = B_B;
        B_AR:    bs_d = B_R;
        default: bs_d = B_IDLE;
      endcase
    end else if (tmo) begin
      bs_d  = B_IDLE;
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge ulpi_clk) begin
    if (ulpi_rst) begin
      st_q   <= S_WAIT;
      bs_q   <= B_IDLE;
      dly_q  <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      pcnt_q <= '0;
      pend_q <= 1'b0;
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
      vid_q  <= '0;
      pid_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      awv_q  <= 1'b0;
      wv_q   <= 1'b0;
      arv_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      bs_q   <= bs_d;
      dly_q  <= dly_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      pcnt_q <= pcnt_d;
      pend_q <= pend_d;
      rdy_q  <= rdy_d;
      err_q  <= err_d;
      vid_q  <= vid_d;
      pid_q  <= pid_d;
      addr_q <= addr_d;
      data_q <= data_d;
      awv_q  <= (bs_d == B_AW);
      wv_q   <= (bs_d == B_W);
      arv_q  <= (bs_d == B_AR);
      busy_q <= (bs_d != B_IDLE);
    end
  end

  assign csr.awvalid = awv_q;
  assign csr.awaddr  = {26'd0, addr_q};
  assign csr.wvalid  = wv_q;
  assign csr.wdata   = {24'd0, data_q};
  assign csr.wstrb   = 4'b0001;
  assign csr.bready  = 1'b1;
  assign csr.arvalid = arv_q;
  assign csr.araddr  = {26'd0, addr_q};
  assign csr.rready  = 1'b1;

  assign unused_ok = &{1'b0, csr.bresp, csr.rresp,
                       csr.rdata[31:8]};

  assign phy_ready  = rdy_q;
  assign phy_error  = err_q;
  assign busy       = busy_q;
  assign vendor_id  = vid_q;
  assign product_id = pid_q;

endmodule
